// File: rtl/tm_class_argmax_pkg.sv
// Shared definitions for the class arg-max stage: FSM encoding and default sizes.
package tm_class_argmax_pkg;

   localparam int unsigned DEF_NUM_CLASSES = 10;
   localparam int unsigned DEF_INT_SIZE    = 32;
   localparam int unsigned DEF_IDX_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

endpackage : tm_class_argmax_pkg

// File: rtl/tm_class_argmax_if.sv
// Prediction result port: valid/ready handshake carrying {class, sum, tie}.
interface tm_class_argmax_if #(
   parameter int unsigned INT_SIZE = 32,
   parameter int unsigned IDX_W    = 4
) ();

   logic                       pred_valid;
   logic                       pred_ready;
   logic [IDX_W-1:0]           pred_class;
   logic signed [INT_SIZE-1:0] pred_sum;
   logic                       pred_tie;

   modport master (
      output pred_valid,
      output pred_class,
      output pred_sum,
      output pred_tie,
      input  pred_ready
   );

   modport slave (
      input  pred_valid,
      input  pred_class,
      input  pred_sum,
      input  pred_tie,
      output pred_ready
   );

endinterface : tm_class_argmax_if

// File: rtl/tm_sum_clamp.sv
// Combinational saturation of one signed class sum to [-T, +T].
module tm_sum_clamp #(
   parameter int unsigned INT_SIZE = 32,
   parameter int          T        = 2000,
   parameter bit          CLAMP_EN = 1'b1
) (
   input  logic signed [INT_SIZE-1:0] sum_in,
   output logic signed [INT_SIZE-1:0] sum_c
);

   localparam logic signed [INT_SIZE-1:0] POS_T = INT_SIZE'(T);
   localparam logic signed [INT_SIZE-1:0] NEG_T = -POS_T;

   // Saturate above +T and below -T; pass through otherwise or when disabled.
   always_comb begin
      sum_c = sum_in;
      if (CLAMP_EN) begin
         if (sum_in > POS_T) begin
            sum_c = POS_T;
         end else if (sum_in < NEG_T) begin
            sum_c = NEG_T;
         end
      end
   end

endmodule : tm_sum_clamp

// File: rtl/tm_class_argmax.sv
// Captures classifier sums on full_done rising edge, scans one class per cycle
// for the maximum, and hands the winner off on a valid/ready port.
module tm_class_argmax
   import tm_class_argmax_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int unsigned INT_SIZE    = DEF_INT_SIZE,
   parameter int          T           = 2000,
   parameter bit          CLAMP_EN    = 1'b1,
   parameter int unsigned IDX_W       = DEF_IDX_W
) (
   input  logic                            clk,
   input  logic                            rst_flag,
   input  logic [NUM_CLASSES*INT_SIZE-1:0] class_sums,
   input  logic                            full_done,
   tm_class_argmax_if.master               pred,
   output logic                            busy,
   output logic                            overrun,
   output logic [15:0]                     result_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_e                     state_q, state_d;
   logic                       full_done_q;
   logic                       start;
   logic                       handshake;
   logic                       do_capture;

   logic signed [INT_SIZE-1:0] clamped_c [NUM_CLASSES];
   logic signed [INT_SIZE-1:0] cap_q     [NUM_CLASSES];
   logic signed [INT_SIZE-1:0] cap_d     [NUM_CLASSES];
   logic signed [INT_SIZE-1:0] scan_val;

   logic [IDX_W-1:0]           idx_q, idx_d;
   logic signed [INT_SIZE-1:0] max_q, max_d;
   logic [IDX_W-1:0]           arg_q, arg_d;
   logic                       tie_q, tie_d;

   logic                       pred_valid_q;
   logic [IDX_W-1:0]           pred_class_q, pred_class_d;
   logic signed [INT_SIZE-1:0] pred_sum_q, pred_sum_d;
   logic                       pred_tie_q, pred_tie_d;
   logic                       busy_q;
   logic                       overrun_q, overrun_d;
   logic [15:0]                count_q, count_d;

   // One clamp per class at the capture input.
   for (genvar g = 0; g < int'(NUM_CLASSES); g++) begin : g_clamp
      tm_sum_clamp #(
         .INT_SIZE (INT_SIZE),
         .T        (T),
         .CLAMP_EN (CLAMP_EN)
      ) u_clamp (
         .sum_in (class_sums[g*INT_SIZE +: INT_SIZE]),
         .sum_c  (clamped_c[g])
      );
   end

   assign start     = full_done && !full_done_q;
   assign handshake = pred_valid_q && pred.pred_ready;
   assign scan_val  = cap_q[idx_q];

   // Next-state and datapath update for the IDLE -> SCAN -> HOLD sequence.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      max_d        = max_q;
      arg_d        = arg_q;
      tie_d        = tie_q;
      cap_d        = cap_q;
      pred_class_d = pred_class_q;
      pred_sum_d   = pred_sum_q;
      pred_tie_d   = pred_tie_q;
      overrun_d    = overrun_q;
      count_d      = count_q;
      do_capture   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               do_capture = 1'b1;
               state_d    = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (start) begin
               overrun_d = 1'b1;
            end
            if (scan_val > max_q) begin
               max_d = scan_val;
               arg_d = idx_q;
               tie_d = 1'b0;
            end else if (scan_val == max_q) begin
               tie_d = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
               state_d      = ST_HOLD;
               pred_class_d = arg_d;
               pred_sum_d   = max_d;
               pred_tie_d   = tie_d;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_HOLD: begin
            if (handshake) begin
               count_d = count_q + 16'd1;
               if (start) begin
                  do_capture = 1'b1;
                  state_d    = ST_SCAN;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (start) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (do_capture) begin
         cap_d = clamped_c;
         max_d = clamped_c[0];
         arg_d = '0;
         tie_d = 1'b0;
         idx_d = IDX_W'(1);
      end
   end

   // State, capture array and registered outputs.
   always_ff @(posedge clk) begin
      if (rst_flag) begin
         state_q      <= ST_IDLE;
         full_done_q  <= 1'b0;
         cap_q        <= '{default: '0};
         idx_q        <= '0;
         max_q        <= '0;
         arg_q        <= '0;
         tie_q        <= 1'b0;
         pred_valid_q <= 1'b0;
         pred_class_q <= '0;
         pred_sum_q   <= '0;
         pred_tie_q   <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         full_done_q  <= full_done;
         cap_q        <= cap_d;
         idx_q        <= idx_d;
         max_q        <= max_d;
         arg_q        <= arg_d;
         tie_q        <= tie_d;
         pred_valid_q <= (state_d == ST_HOLD);
         pred_class_q <= pred_class_d;
         pred_sum_q   <= pred_sum_d;
         pred_tie_q   <= pred_tie_d;
         busy_q       <= (state_d != ST_IDLE);
         overrun_q    <= overrun_d;
         count_q      <= count_d;
      end
   end

   assign pred.pred_valid = pred_valid_q;
   assign pred.pred_class = pred_class_q;
   assign pred.pred_sum   = pred_sum_q;
   assign pred.pred_tie   = pred_tie_q;
   assign busy            = busy_q;
   assign overrun         = overrun_q;
   assign result_count    = count_q;

endmodule : tm_class_argmax

// File: tb/tb_tm_class_argmax.sv
// Directed bench for tm_class_argmax at default parameters (10 classes, 32-bit, T=2000).
module tb_tm_class_argmax;

   localparam int unsigned NC = 10;
   localparam int unsigned IS = 32;
   localparam int unsigned IW = 4;

   logic              clk;
   logic              rst_flag;
   logic [NC*IS-1:0]  class_sums;
   logic              full_done;
   logic              busy;
   logic              overrun;
   logic [15:0]       result_count;

   int                sv_vec [NC];
   int                n_checks;
   int                n_pass;

   tm_class_argmax_if #(.INT_SIZE(IS), .IDX_W(IW)) pif ();

   tm_class_argmax #(
      .NUM_CLASSES (NC),
      .INT_SIZE    (IS),
      .T           (2000),
      .CLAMP_EN    (1'b1),
      .IDX_W       (IW)
   ) dut (
      .clk          (clk),
      .rst_flag     (rst_flag),
      .class_sums   (class_sums),
      .full_done    (full_done),
      .pred         (pif.master),
      .busy         (busy),
      .overrun      (overrun),
      .result_count (result_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_sums();
      for (int i = 0; i < int'(NC); i++) begin
         class_sums[i*IS +: IS] = 32'(sv_vec[i]);
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!pif.pred_valid && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_one(output int lat);
      full_done = 1'b1;
      tick();
      full_done = 1'b0;
      wait_valid(lat);
   endtask

   task automatic handshake();
      pif.pred_ready = 1'b1;
      tick();
      pif.pred_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_flag = 1'b1;
      tick();
      rst_flag = 1'b0;
   endtask

   task automatic test_reset();
      pulse_reset();
      n_checks++;
      if ({busy, pif.pred_valid, overrun, pif.pred_tie} !== 4'b0000)
         $display("FAIL reset_flags: busy/valid/overrun/tie=%b required 0000",
                  {busy, pif.pred_valid, overrun, pif.pred_tie});
      else n_pass++;
      n_checks++;
      if (result_count !== 16'd0 || pif.pred_class !== 4'd0 || pif.pred_sum !== 32'sd0)
         $display("FAIL reset_data: count=%0d class=%0d sum=%0d required 0/0/0",
                  result_count, pif.pred_class, pif.pred_sum);
      else n_pass++;
   endtask

   task automatic test_basic();
      int lat;
      sv_vec = '{5, -3, 12, 0, 7, 1, 2, 3, 4, 11};
      apply_sums();
      run_one(lat);
      n_checks++;
      if (lat !== 9) $display("FAIL basic_latency: got %0d required 9", lat);
      else n_pass++;
      n_checks++;
      if (pif.pred_class !== 4'd2 || pif.pred_sum !== 32'sd12 || pif.pred_tie !== 1'b0)
         $display("FAIL basic_result: class=%0d sum=%0d tie=%0b required 2/12/0",
                  pif.pred_class, pif.pred_sum, pif.pred_tie);
      else n_pass++;
      handshake();
      n_checks++;
      if (result_count !== 16'd1 || pif.pred_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL basic_handoff: count=%0d valid=%0b busy=%0b required 1/0/0",
                  result_count, pif.pred_valid, busy);
      else n_pass++;
   endtask

   task automatic test_ties();
      int lat;
      sv_vec = '{9, 9, 1, 1, 1, 1, 1, 1, 1, 1};
      apply_sums();
      run_one(lat);
      n_checks++;
      if (pif.pred_class !== 4'd0 || pif.pred_sum !== 32'sd9 || pif.pred_tie !== 1'b1)
         $display("FAIL tie_first_two: class=%0d sum=%0d tie=%0b required 0/9/1",
                  pif.pred_class, pif.pred_sum, pif.pred_tie);
      else n_pass++;
      handshake();
      sv_vec = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
      apply_sums();
      run_one(lat);
      n_checks++;
      if (pif.pred_class !== 4'd0 || pif.pred_sum !== -32'sd7 || pif.pred_tie !== 1'b1)
         $display("FAIL tie_all_neg: class=%0d sum=%0d tie=%0b required 0/-7/1",
                  pif.pred_class, pif.pred_sum, pif.pred_tie);
      else n_pass++;
      handshake();
   endtask

   task automatic test_clamp();
      int lat;
      sv_vec = '{0, 0, 0, 0, 5000, 0, 0, 2000, 0, 0};
      apply_sums();
      run_one(lat);
      n_checks++;
      if (pif.pred_class !== 4'd4 || pif.pred_sum !== 32'sd2000 || pif.pred_tie !== 1'b1)
         $display("FAIL clamp_pos: class=%0d sum=%0d tie=%0b required 4/2000/1",
                  pif.pred_class, pif.pred_sum, pif.pred_tie);
      else n_pass++;
      handshake();
      sv_vec = '{-9000, -2500, -2500, -2500, -2500, -2500, -2500, -2500, -2500, -2500};
      apply_sums();
      run_one(lat);
      n_checks++;
      if (pif.pred_class !== 4'd0 || pif.pred_sum !== -32'sd2000 || pif.pred_tie !== 1'b1)
         $display("FAIL clamp_neg: class=%0d sum=%0d tie=%0b required 0/-2000/1",
                  pif.pred_class, pif.pred_sum, pif.pred_tie);
      else n_pass++;
      handshake();
   endtask

   task automatic test_level_held();
      logic [15:0] base;
      base = result_count;
      sv_vec = '{0, 1, 2, 3, 4, 5, 6, 7, 8, -1};
      apply_sums();
      pif.pred_ready = 1'b1;
      full_done = 1'b1;
      repeat (30) tick();
      full_done = 1'b0;
      pif.pred_ready = 1'b0;
      tick();
      n_checks++;
      if (result_count !== 16'(base + 16'd1) || busy !== 1'b0 || overrun !== 1'b0)
         $display("FAIL level_held: count=%0d busy=%0b overrun=%0b required %0d/0/0",
                  result_count, busy, overrun, 16'(base + 16'd1));
      else n_pass++;
      n_checks++;
      if (pif.pred_class !== 4'd8 || pif.pred_sum !== 32'sd8)
         $display("FAIL level_result: class=%0d sum=%0d required 8/8",
                  pif.pred_class, pif.pred_sum);
      else n_pass++;
   endtask

   task automatic test_overrun_stall();
      int lat;
      int unstable;
      sv_vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      apply_sums();
      full_done = 1'b1;
      tick();
      full_done = 1'b0;
      tick();
      tick();
      sv_vec = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
      apply_sums();
      full_done = 1'b1;
      tick();
      full_done = 1'b0;
      n_checks++;
      if (overrun !== 1'b1 || busy !== 1'b1)
         $display("FAIL overrun_flag: overrun=%0b busy=%0b required 1/1", overrun, busy);
      else n_pass++;
      wait_valid(lat);
      n_checks++;
      if (pif.pred_valid !== 1'b1 || pif.pred_class !== 4'd9 || pif.pred_sum !== 32'sd10 ||
          pif.pred_tie !== 1'b0)
         $display("FAIL overrun_result: valid=%0b class=%0d sum=%0d tie=%0b required 1/9/10/0",
                  pif.pred_valid, pif.pred_class, pif.pred_sum, pif.pred_tie);
      else n_pass++;
      unstable = 0;
      repeat (20) begin
         tick();
         if (pif.pred_valid !== 1'b1 || pif.pred_class !== 4'd9 || pif.pred_sum !== 32'sd10 ||
             pif.pred_tie !== 1'b0)
            unstable++;
      end
      n_checks++;
      if (unstable !== 0)
         $display("FAIL stall_stable: unstable cycles=%0d required 0", unstable);
      else n_pass++;
      handshake();
      n_checks++;
      if (overrun !== 1'b1 || pif.pred_valid !== 1'b0)
         $display("FAIL overrun_sticky: overrun=%0b valid=%0b required 1/0", overrun, pif.pred_valid);
      else n_pass++;
   endtask

   task automatic test_mid_scan_reset();
      int lat;
      sv_vec = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
      apply_sums();
      full_done = 1'b1;
      tick();
      full_done = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (busy !== 1'b1 || overrun !== 1'b1 || result_count === 16'd0)
         $display("FAIL pre_reset: busy=%0b overrun=%0b count=%0d required 1/1/nonzero",
                  busy, overrun, result_count);
      else n_pass++;
      pulse_reset();
      n_checks++;
      if (busy !== 1'b0 || pif.pred_valid !== 1'b0 || overrun !== 1'b0 || result_count !== 16'd0)
         $display("FAIL mid_reset: busy=%0b valid=%0b overrun=%0b count=%0d required 0/0/0/0",
                  busy, pif.pred_valid, overrun, result_count);
      else n_pass++;
      run_one(lat);
      n_checks++;
      if (lat !== 9 || pif.pred_class !== 4'd5 || pif.pred_sum !== 32'sd9 || pif.pred_tie !== 1'b0)
         $display("FAIL post_reset: lat=%0d class=%0d sum=%0d tie=%0b required 9/5/9/0",
                  lat, pif.pred_class, pif.pred_sum, pif.pred_tie);
      else n_pass++;
      handshake();
   endtask

   task automatic test_back_to_back();
      int lat;
      pulse_reset();
      sv_vec = '{0, 0, 0, 50, 0, 0, 0, 0, 0, 0};
      apply_sums();
      run_one(lat);
      n_checks++;
      if (pif.pred_class !== 4'd3 || pif.pred_sum !== 32'sd50 || pif.pred_tie !== 1'b0)
         $display("FAIL b2b_first: class=%0d sum=%0d tie=%0b required 3/50/0",
                  pif.pred_class, pif.pred_sum, pif.pred_tie);
      else n_pass++;
      sv_vec = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, 0};
      apply_sums();
      full_done = 1'b1;
      pif.pred_ready = 1'b1;
      tick();
      full_done = 1'b0;
      pif.pred_ready = 1'b0;
      n_checks++;
      if (pif.pred_valid !== 1'b0 || busy !== 1'b1 || overrun !== 1'b0 || result_count !== 16'd1)
         $display("FAIL b2b_handoff: valid=%0b busy=%0b overrun=%0b count=%0d required 0/1/0/1",
                  pif.pred_valid, busy, overrun, result_count);
      else n_pass++;
      wait_valid(lat);
      n_checks++;
      if (lat !== 9 || pif.pred_class !== 4'd9 || pif.pred_sum !== 32'sd0 || pif.pred_tie !== 1'b0)
         $display("FAIL b2b_second: lat=%0d class=%0d sum=%0d tie=%0b required 9/9/0/0",
                  lat, pif.pred_class, pif.pred_sum, pif.pred_tie);
      else n_pass++;
      handshake();
      n_checks++;
      if (result_count !== 16'd2 || overrun !== 1'b0)
         $display("FAIL b2b_count: count=%0d overrun=%0b required 2/0", result_count, overrun);
      else n_pass++;
   endtask

   task automatic test_count_wrap();
      int lat;
      force dut.count_q = 16'hFFFE;
      tick();
      release dut.count_q;
      tick();
      n_checks++;
      if (result_count !== 16'hFFFE)
         $display("FAIL wrap_preload: count=%h required fffe", result_count);
      else n_pass++;
      sv_vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      apply_sums();
      run_one(lat);
      handshake();
      n_checks++;
      if (result_count !== 16'hFFFF)
         $display("FAIL wrap_ffff: count=%h required ffff", result_count);
      else n_pass++;
      run_one(lat);
      handshake();
      n_checks++;
      if (result_count !== 16'h0000)
         $display("FAIL wrap_zero: count=%h required 0000", result_count);
      else n_pass++;
   endtask

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      rst_flag       = 1'b1;
      full_done      = 1'b0;
      class_sums     = '0;
      pif.pred_ready = 1'b0;
      repeat (2) tick();
      test_reset();
      test_basic();
      test_ties();
      test_clamp();
      test_level_held();
      test_overrun_stall();
      test_mid_scan_reset();
      test_back_to_back();
      test_count_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_tm_class_argmax
